// File: rtl/counter_ascii_tx_if.sv
// Request/UART-byte bundle for counter_ascii_tx: master is the reporter, slave is the counter + uart_tx side.
interface counter_ascii_tx_if #(
  parameter int VALUE_W = 14
);
  logic               send_req;
  logic [VALUE_W-1:0] value;
  logic               tx_busy;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               busy;
  logic               done;

  modport master (
    input  send_req, value, tx_busy,
    output tx_start, tx_data, busy, done
  );

  modport slave (
    output send_req, value, tx_busy,
    input  tx_start, tx_data, busy, done
  );
endinterface

// File: rtl/counter_ascii_tx.sv
// Captures a counter value, converts it to NUM_DIGITS ASCII decimal chars (MSD first) and strobes them into uart_tx;
// first strobe <= NUM_DIGITS*11+2 cycles after request, each byte waits on tx_busy. CRLF_EN appends CR LF.
module counter_ascii_tx #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic              clk,
  input  logic              rst,
  counter_ascii_tx_if.master bus
);
`ifdef CRLF_EN
  localparam int NUM_CHARS = NUM_DIGITS + 2;
`else
  localparam int NUM_CHARS = NUM_DIGITS;
`endif
  localparam int unsigned MAX_VAL = 10**NUM_DIGITS - 1;

  typedef enum logic [2:0] {IDLE, CONV, SEND, ACK, DRAIN, FIN} state_t;

  state_t                  state, state_nxt;
  logic [VALUE_W-1:0]      rem, rem_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [2:0]              dig_idx, dig_idx_nxt;
  logic [2:0]              char_idx, char_idx_nxt;
  logic [1:0]              ack_cnt, ack_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] digits, digits_nxt;
  logic                    tx_start_q, tx_start_nxt;
  logic [7:0]              tx_data_q, tx_data_nxt;
  logic                    busy_q, busy_nxt;
  logic                    done_q, done_nxt;
  logic [VALUE_W-1:0]      divisor;
  logic [7:0]              char_byte;

  function automatic logic [VALUE_W-1:0] pow10(input logic [2:0] e);
    case (e)
      3'd1:    return VALUE_W'(10);
      3'd2:    return VALUE_W'(100);
      3'd3:    return VALUE_W'(1000);
      3'd4:    return VALUE_W'(10000);
      default: return VALUE_W'(1);
    endcase
  endfunction

  assign divisor = pow10(3'(NUM_DIGITS - 1) - dig_idx);

  always_comb begin
    char_byte = 8'h30 + {4'h0, digits[char_idx*4 +: 4]};
`ifdef CRLF_EN
    if (char_idx == 3'(NUM_DIGITS))
      char_byte = 8'h0D;
    else if (char_idx == 3'(NUM_DIGITS + 1))
      char_byte = 8'h0A;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      cnt        <= '0;
      dig_idx    <= '0;
      char_idx   <= '0;
      ack_cnt    <= '0;
      digits     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      cnt        <= cnt_nxt;
      dig_idx    <= dig_idx_nxt;
      char_idx   <= char_idx_nxt;
      ack_cnt    <= ack_cnt_nxt;
      digits     <= digits_nxt;
      tx_start_q <= tx_start_nxt;
      tx_data_q  <= tx_data_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    cnt_nxt      = cnt;
    dig_idx_nxt  = dig_idx;
    char_idx_nxt = char_idx;
    ack_cnt_nxt  = ack_cnt;
    digits_nxt   = digits;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data_q;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.send_req) begin
          rem_nxt     = (32'(bus.value) > MAX_VAL) ? VALUE_W'(MAX_VAL) : bus.value;
          cnt_nxt     = '0;
          dig_idx_nxt = '0;
          busy_nxt    = 1'b1;
          state_nxt   = CONV;
        end
      end
      // One subtraction per cycle; the failing compare stores the digit.
      CONV: begin
        if (rem >= divisor) begin
          rem_nxt = rem - divisor;
          cnt_nxt = cnt + 4'd1;
        end else begin
          digits_nxt[dig_idx*4 +: 4] = cnt;
          cnt_nxt = '0;
          if (dig_idx == 3'(NUM_DIGITS - 1)) begin
            char_idx_nxt = '0;
            state_nxt    = SEND;
          end else begin
            dig_idx_nxt = dig_idx + 3'd1;
          end
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = char_byte;
          ack_cnt_nxt  = '0;
          state_nxt    = ACK;
        end
      end
      // A uart_tx that never raises busy must not stall the frame.
      ACK: begin
        if (bus.tx_busy || ack_cnt == 2'd3)
          state_nxt = DRAIN;
        else
          ack_cnt_nxt = ack_cnt + 2'd1;
      end
      DRAIN: begin
        if (!bus.tx_busy) begin
          if (char_idx == 3'(NUM_CHARS - 1)) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = FIN;
          end else begin
            char_idx_nxt = char_idx + 3'd1;
            state_nxt    = SEND;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_counter_ascii_tx.sv
// Bench for counter_ascii_tx: random/directed requests, uart_tx responder model, queue scoreboard.
module tb_counter_ascii_tx;
  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 14;
`ifdef CRLF_EN
  localparam int NUM_CHARS = NUM_DIGITS + 2;
`else
  localparam int NUM_CHARS = NUM_DIGITS;
`endif
  localparam int MAX_VAL = 10**NUM_DIGITS - 1;
  localparam int LAT_MAX = NUM_DIGITS*11 + 2;

  logic clk = 1'b0;
  logic rst;

  counter_ascii_tx_if #(.VALUE_W(VALUE_W)) bus();

  counter_ascii_tx #(.NUM_DIGITS(NUM_DIGITS), .VALUE_W(VALUE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         frame_q[$];
  int         done_seen = 0;
  int         start_seen = 0;
  int         frames_req = 0;
  bit         force_busy = 0;
  bit         no_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: saturate, then decimal digits by division, MSD first.
  function automatic void push_expected(input int v);
    int s;
    int pw;
    s = (v > MAX_VAL) ? MAX_VAL : v;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      pw = 1;
      for (int k = 0; k < d; k++) pw *= 10;
      exp_q.push_back(8'(32'h30 + (s / pw) % 10));
    end
`ifdef CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    frame_q.push_back(NUM_CHARS);
    frames_req++;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // uart_tx model: busy for a random bit-time after each strobe.
  initial begin
    int left;
    left = 0;
    bus.tx_busy = 1'b0;
    forever begin
      tick();
      if (rst) begin
        left = 0;
        bus.tx_busy = 1'b0;
      end else if (force_busy) begin
        bus.tx_busy = 1'b1;
      end else if (left > 0) begin
        left--;
        if (left == 0) bus.tx_busy = 1'b0;
      end else if (bus.tx_start && !no_ack) begin
        bus.tx_busy = 1'b1;
        left = $urandom_range(2, 10);
      end else begin
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expected bytes on every strobe, frame length on every done.
  initial begin
    int in_frame;
    bit prev_start;
    in_frame = 0;
    prev_start = 0;
    forever begin
      tick();
      if (rst) begin
        exp_q.delete();
        frame_q.delete();
        in_frame = 0;
        prev_start = 0;
      end else begin
        if (bus.tx_start) begin
          start_seen++;
          in_frame++;
          check("strobe_one_cycle", 32'(prev_start), 0);
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
          end else begin
            check("tx_data", bus.tx_data, exp_q.pop_front());
          end
        end
        if (bus.done) begin
          done_seen++;
          if (frame_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got done=1 expected 0");
          end else begin
            check("frame_len", in_frame, frame_q.pop_front());
          end
          in_frame = 0;
        end
        prev_start = bus.tx_start;
      end
    end
  end

  task automatic req(input int v);
    bus.value    = VALUE_W'(v);
    bus.send_req = 1'b1;
    push_expected(v);
    tick();
    bus.send_req = 1'b0;
    check("busy_after_req", bus.busy, 1);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!bus.done && n < bound) begin
      tick();
      n++;
    end
    if (!bus.done) begin
      n_chk++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles expected done=1", name, n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_start"}, bus.tx_start, 0);
    check({name, "_tx_data"},  bus.tx_data,  8'h00);
    check({name, "_busy"},     bus.busy,     0);
    check({name, "_done"},     bus.done,     0);
  endtask

  initial begin
    int cyc;
    int s0;
    int dir_vals[6];
    dir_vals = '{1234, 0, 9999, 12000, 7, 16383};
    rst = 1'b1;
    bus.send_req = 1'b0;
    bus.value = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // First-strobe latency with an idle uart
    req(1234);
    cyc = 1;
    while (!bus.tx_start && cyc < 200) begin
      tick();
      cyc++;
    end
    check("latency_within_bound", 32'(cyc <= LAT_MAX), 1);
    wait_done("latency_frame", 2000);
    tick();

    foreach (dir_vals[i]) begin
      req(dir_vals[i]);
      wait_done("directed", 2000);
      tick();
    end

    repeat (8) begin
      req(int'($urandom_range(0, 16383)));
      wait_done("random", 2000);
      tick();
    end

    // uart busy for 500 cycles at request time
    force_busy = 1;
    tick();
    tick();
    s0 = start_seen;
    req(4321);
    repeat (500) tick();
    check("no_start_while_busy", start_seen - s0, 0);
    force_busy = 0;
    wait_done("held_busy", 2000);
    tick();

    // Requests during an active frame are dropped
    req(5678);
    for (int i = 0; i < 30; i++) begin
      bus.value = VALUE_W'($urandom_range(0, 9999));
      bus.send_req = (i % 3 == 0) && bus.busy;
      tick();
    end
    bus.send_req = 1'b0;
    wait_done("spam", 2000);
    bus.value = VALUE_W'(1111);
    bus.send_req = 1'b1;
    tick();
    bus.send_req = 1'b0;
    check("req_during_done_ignored", bus.busy, 0);
    req(2468);
    wait_done("back_to_back", 2000);
    tick();

    // Reset after the second byte
    s0 = start_seen;
    req(1234);
    cyc = 0;
    while (start_seen - s0 < 2 && cyc < 500) begin
      tick();
      cyc++;
    end
    check("two_bytes_before_reset", 32'(start_seen - s0 >= 2), 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    frames_req--;
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
    req(1234);
    wait_done("after_reset", 2000);
    tick();

    // uart that never acknowledges
    no_ack = 1;
    req(int'($urandom_range(0, 9999)));
    wait_done("no_ack", 2000);
    tick();
    req(7);
    wait_done("no_ack_2", 2000);
    tick();
    no_ack = 0;

    repeat (20) tick();
    check("bytes_left", exp_q.size(), 0);
    check("frames_done", done_seen, frames_req);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end
endmodule
